// File: rtl/vga_pixel_buffer_pkg.sv
// Shared definitions for the VGA pixel buffer slice.
//   PIX_W        : pixel width (3-bit RGB, 3'bRGB)
//   BLACK/RED/WHITE : common colour constants
//   vga_state_t  : buffer alignment / streaming state
package vga_pkg;

  localparam int PIX_W = 3;

  localparam logic [PIX_W-1:0] BLACK = 3'b000;
  localparam logic [PIX_W-1:0] RED   = 3'b100;
  localparam logic [PIX_W-1:0] WHITE = 3'b111;

  typedef enum logic [1:0] {
    WAIT_SOF,  // discarding pixels until a camera start-of-frame
    FILL,      // buffering, waiting for prefill and a display frame_start
    STREAM,    // popping pixels on the display read strobe
    FLUSH      // one-cycle clear after an underrun
  } vga_state_t;

endpackage

// File: rtl/vga_pixel_buffer_if.sv
// Bus between the camera/display side (master) and the pixel buffer (slave).
//   wr_en, wr_sof, wr_data : camera pixel write (wr_sof marks first pixel of a frame)
//   wr_ready               : buffer not full (registered)
//   frame_start            : display frame start pulse
//   read                   : display pop request
//   data                   : popped pixel
//   fill_level             : current occupancy, ADDR_W+1 bits
//   underrun, overflow     : one-cycle error pulses
interface vga_pixel_buffer_if #(
  parameter int ADDR_W = 10
);
  import vga_pkg::*;

  logic             wr_en;
  logic             wr_sof;
  logic [PIX_W-1:0] wr_data;
  logic             wr_ready;
  logic             frame_start;
  logic             read;
  logic [PIX_W-1:0] data;
  logic [ADDR_W:0]  fill_level;
  logic             underrun;
  logic             overflow;

  modport master (
    output wr_en, wr_sof, wr_data, frame_start, read,
    input  wr_ready, data, fill_level, underrun, overflow
  );

  modport slave (
    input  wr_en, wr_sof, wr_data, frame_start, read,
    output wr_ready, data, fill_level, underrun, overflow
  );

endinterface

// File: rtl/vga_pixel_buffer_ram.sv
// Simple dual-port synchronous RAM, DEPTH x PIX_W, for block-RAM inference.
//   clk     : clock
//   we_i    : write enable, waddr_i/wdata_i : write port
//   re_i    : read enable,  raddr_i         : read address
//   rdata_o : registered read data, holds its value while re_i is low
module vga_pixel_ram
  import vga_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [PIX_W-1:0]  wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [PIX_W-1:0]  rdata_o
);

  logic [PIX_W-1:0] mem_q [DEPTH];
  logic [PIX_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/vga_pixel_buffer.sv
// Pixel FIFO between the camera capture path and vga_display. Aligns the
// write stream to a camera start-of-frame, prefills, then releases pixels on
// the display read strobe from the first sufficiently-filled frame_start.
// Underrun flushes the buffer and realigns to the next camera frame.
//   clk_25 : pixel clock
//   reset  : synchronous, active-high
//   bus    : vga_pixel_buffer_if slave (write, read, status and error flags)
module vga_pixel_buffer
  import vga_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int ADDR_W  = 10,
  parameter int PREFILL = 512
) (
  input  logic              clk_25,
  input  logic              reset,
  vga_pixel_buffer_if.slave bus
);

  localparam logic [ADDR_W:0] DEPTH_C   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] PREFILL_C = (ADDR_W+1)'(PREFILL);

  vga_state_t        state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              show_q, show_d;  // 1: data shows the RAM read register, 0: BLACK
  logic              wr_ready_q, wr_ready_d;
  logic              underrun_q, underrun_d;
  logic              overflow_q, overflow_d;

  logic              full, empty, wr_accept, pop;
  logic [PIX_W-1:0]  ram_rdata;

  always_comb begin
    full       = (count_q == DEPTH_C);
    empty      = (count_q == '0);
    state_d    = state_q;
    wr_accept  = 1'b0;
    pop        = 1'b0;
    show_d     = show_q;
    underrun_d = 1'b0;
    overflow_d = 1'b0;

    case (state_q)
      WAIT_SOF: begin
        // Count is always zero here, so the sof pixel can never overflow.
        if (bus.wr_en && bus.wr_sof) begin
          wr_accept = 1'b1;
          state_d   = FILL;
        end
      end
      FILL: begin
        wr_accept  = bus.wr_en && !full;
        overflow_d = bus.wr_en && full;
        // Pre-edge count: a same-cycle write does not help reach prefill.
        if (bus.frame_start && (count_q >= PREFILL_C)) begin
          state_d = STREAM;
        end
      end
      STREAM: begin
        // Full is not bypassed by a same-cycle pop.
        wr_accept  = bus.wr_en && !full;
        overflow_d = bus.wr_en && full;
        if (bus.read) begin
          if (empty) begin
            underrun_d = 1'b1;
            show_d     = 1'b0;
            state_d    = FLUSH;
          end else begin
            pop    = 1'b1;
            show_d = 1'b1;
          end
        end
      end
      FLUSH: begin
        show_d  = 1'b0;
        state_d = WAIT_SOF;
      end
      default: state_d = WAIT_SOF;
    endcase

    wr_ptr_d = wr_ptr_q + ADDR_W'(wr_accept);
    rd_ptr_d = rd_ptr_q + ADDR_W'(pop);
    case ({wr_accept, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // A write landing on the underrun edge is discarded here as well.
    if (state_q == FLUSH) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end

    wr_ready_d = (count_d != DEPTH_C);
  end

  always_ff @(posedge clk_25) begin
    if (reset) begin
      state_q    <= WAIT_SOF;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      show_q     <= 1'b0;
      wr_ready_q <= 1'b1;
      underrun_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      show_q     <= show_d;
      wr_ready_q <= wr_ready_d;
      underrun_q <= underrun_d;
      overflow_q <= overflow_d;
    end
  end

  // Write and read addresses never collide: a pop needs count >= 1 and a
  // write at the read address would need count == 0 or a (rejected) full write.
  vga_pixel_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk_25),
    .we_i    (wr_accept),
    .waddr_i (wr_ptr_q),
    .wdata_i (bus.wr_data),
    .re_i    (pop),
    .raddr_i (rd_ptr_q),
    .rdata_o (ram_rdata)
  );

  assign bus.data       = show_q ? ram_rdata : BLACK;
  assign bus.fill_level = count_q;
  assign bus.wr_ready   = wr_ready_q;
  assign bus.underrun   = underrun_q;
  assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_vga_pixel_buffer.sv
module tb_vga_pixel_buffer;
  import vga_pkg::*;

  localparam int DEPTH   = 16;
  localparam int ADDR_W  = 4;
  localparam int PREFILL = 8;

  logic clk_25 = 1'b0;
  logic reset  = 1'b1;
  always #20 clk_25 = ~clk_25;

  vga_pixel_buffer_if #(.ADDR_W(ADDR_W)) bus ();

  vga_pixel_buffer #(
    .DEPTH   (DEPTH),
    .ADDR_W  (ADDR_W),
    .PREFILL (PREFILL)
  ) dut (
    .clk_25 (clk_25),
    .reset  (reset),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic chk(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a queue of pixels plus the alignment mode.
  logic [2:0] m_q[$];
  vga_state_t m_state = WAIT_SOF;
  logic [2:0] m_data  = BLACK;
  bit         m_ready = 1'b1;
  bit         m_under = 1'b0;
  bit         m_over  = 1'b0;
  int         m_pops  = 0;

  always @(posedge clk_25) begin : model_b
    int pre;
    pre     = m_q.size();
    m_under = 1'b0;
    m_over  = 1'b0;
    if (reset) begin
      m_q.delete();
      m_state = WAIT_SOF;
      m_data  = BLACK;
    end else begin
      case (m_state)
        WAIT_SOF: begin
          if (bus.wr_en && bus.wr_sof) begin
            m_q.push_back(bus.wr_data);
            m_state = FILL;
          end
        end
        FILL, STREAM: begin
          if (m_state == STREAM && bus.read) begin
            if (pre == 0) begin
              m_under = 1'b1;
              m_data  = BLACK;
              m_state = FLUSH;
            end else begin
              m_data = m_q.pop_front();
              m_pops++;
              $display("pop %0d: pixel %b, %0d left", m_pops, m_data, m_q.size());
            end
          end
          if (bus.wr_en) begin
            if (pre == DEPTH) m_over = 1'b1;
            else m_q.push_back(bus.wr_data);
          end
          if (m_state == FILL && bus.frame_start && pre >= PREFILL) m_state = STREAM;
        end
        FLUSH: begin
          m_q.delete();
          m_data  = BLACK;
          m_state = WAIT_SOF;
        end
        default: m_state = WAIT_SOF;
      endcase
    end
    m_ready = (m_q.size() != DEPTH);
  end

  // Every-cycle comparison of DUT against the model, away from the active edge.
  always @(negedge clk_25) begin
    if (chk_en) begin
      chk("data",       int'(bus.data),       int'(m_data));
      chk("fill_level", int'(bus.fill_level), m_q.size());
      chk("wr_ready",   int'(bus.wr_ready),   int'(m_ready));
      chk("underrun",   int'(bus.underrun),   int'(m_under));
      chk("overflow",   int'(bus.overflow),   int'(m_over));
      chk("state",      int'(dut.state_q),    int'(m_state));
    end
  end

  task automatic drive(bit we, bit sof, logic [2:0] d, bit fs, bit rd);
    bus.wr_en       = we;
    bus.wr_sof      = sof;
    bus.wr_data     = d;
    bus.frame_start = fs;
    bus.read        = rd;
    @(posedge clk_25);
    @(negedge clk_25);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, BLACK, 1'b0, 1'b0);
  endtask

  task automatic rnd_phase(int cycles, int wr_pct, int rd_pct);
    for (int i = 0; i < cycles; i++) begin
      drive($urandom_range(99) < wr_pct, $urandom_range(99) < 5, 3'($urandom),
            $urandom_range(99) < 4, $urandom_range(99) < rd_pct);
    end
  endtask

  initial begin
    bus.wr_en = 1'b0; bus.wr_sof = 1'b0; bus.wr_data = BLACK;
    bus.frame_start = 1'b0; bus.read = 1'b0;
    reset = 1'b1;
    @(negedge clk_25);
    chk_en = 1'b1;
    idle();
    reset = 1'b0;
    chk("rst_fill",  int'(bus.fill_level), 0);
    chk("rst_ready", int'(bus.wr_ready), 1);
    chk("rst_data",  int'(bus.data), 0);

    // Writes before any start-of-frame are dropped.
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 3'($urandom), 1'b0, 1'b0);
    chk("s1_fill",  int'(bus.fill_level), 0);
    chk("s1_state", int'(dut.state_q), int'(WAIT_SOF));

    // Aligned frame of 10, stream it out, then one extra read underruns.
    drive(1'b1, 1'b1, RED, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) drive(1'b1, 1'b0, 3'($urandom), 1'b0, 1'b0);
    chk("s2_fill", int'(bus.fill_level), 10);
    drive(1'b0, 1'b0, BLACK, 1'b1, 1'b0);
    chk("s2_stream", int'(dut.state_q), int'(STREAM));
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b0, BLACK, 1'b0, 1'b1);
      if (i == 0) chk("s2_first", int'(bus.data), 4);
      chk("s2_dec", int'(bus.fill_level), 9 - i);
    end
    drive(1'b0, 1'b0, BLACK, 1'b0, 1'b1);
    chk("s5_under", int'(bus.underrun), 1);
    chk("s5_data",  int'(bus.data), 0);
    chk("s5_flush", int'(dut.state_q), int'(FLUSH));
    idle();
    chk("s5_wait", int'(dut.state_q), int'(WAIT_SOF));
    drive(1'b1, 1'b0, WHITE, 1'b0, 1'b0);
    chk("s5_drop", int'(bus.fill_level), 0);

    // frame_start with too little fill is ignored.
    drive(1'b1, 1'b1, RED, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 3'($urandom), 1'b0, 1'b0);
    drive(1'b0, 1'b0, BLACK, 1'b1, 1'b1);
    chk("s3_fill_state", int'(dut.state_q), int'(FILL));
    chk("s3_data", int'(bus.data), 0);
    for (int i = 0; i < 2; i++) drive(1'b1, 1'b0, 3'($urandom), 1'b0, 1'b0);
    drive(1'b0, 1'b0, BLACK, 1'b1, 1'b0);
    chk("s3_stream", int'(dut.state_q), int'(STREAM));

    // Fill to full, then overflow twice, then write+pop at full.
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 3'($urandom), 1'b0, 1'b0);
    chk("s4_full", int'(bus.fill_level), 16);
    chk("s4_ready", int'(bus.wr_ready), 0);
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, WHITE, 1'b0, 1'b0);
      chk("s4_over", int'(bus.overflow), 1);
      chk("s4_hold", int'(bus.fill_level), 16);
    end
    drive(1'b1, 1'b0, WHITE, 1'b0, 1'b1);
    chk("s4_over_pop", int'(bus.overflow), 1);
    chk("s4_pop_fill", int'(bus.fill_level), 15);
    for (int i = 0; i < 7; i++) drive(1'b0, 1'b0, BLACK, 1'b0, 1'b1);

    // Reset while streaming with 8 buffered.
    reset = 1'b1;
    idle();
    reset = 1'b0;
    chk("s6_fill",  int'(bus.fill_level), 0);
    chk("s6_data",  int'(bus.data), 0);
    chk("s6_ready", int'(bus.wr_ready), 1);
    chk("s6_state", int'(dut.state_q), int'(WAIT_SOF));

    // Pointer wrap: hold 12 buffered while 50 pixels pass through.
    drive(1'b1, 1'b1, 3'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 11; i++) drive(1'b1, 1'b0, 3'($urandom), 1'b0, 1'b0);
    drive(1'b0, 1'b0, BLACK, 1'b1, 1'b0);
    for (int i = 0; i < 50; i++) drive(1'b1, 1'b0, 3'($urandom), 1'b0, 1'b1);
    chk("wrap_fill", int'(bus.fill_level), 12);
    for (int i = 0; i < 12; i++) drive(1'b0, 1'b0, BLACK, 1'b0, 1'b1);

    // Randomized traffic: write-heavy then read-heavy.
    rnd_phase(800, 80, 30);
    rnd_phase(800, 45, 70);
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
